alu_seq_ctrl: RTL and testbench

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_seq_ctrl_if.sv | 25 ++
 rtl/alu_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Request/response handshake bundle between a requester and the ALU sequencing controller.
// The master side issues operand/opcode requests; the slave side returns the captured result and flags.
interface alu_seq_ctrl_if #(
    parameter int N = 16
);
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic [1:0]   req_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic [4:0]   rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequences one request through an external registered ALU: load A, B and opcode over a shared
// data bus, strobe the update, capture the result, and hold it until the consumer takes it.
module alu_seq_ctrl #(
    parameter int N        = 16,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    alu_seq_ctrl_if.slave      bus,
    output logic [N-1:0]       alu_data,
    output logic               alu_load_A,
    output logic               alu_load_B,
    output logic               alu_load_Op,
    output logic               alu_updateRes,
    input  logic [N-1:0]       alu_result,
    input  logic [4:0]         alu_flags,
    output logic [7:0]         ops_done
);
    typedef enum logic [2:0] {IDLE, LD_A, LD_B, LD_OP, EXEC, CAPT, RESP} state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [N-1:0]      a_reg;
    logic [N-1:0]      b_reg;
    logic [1:0]        op_reg;
    logic [N-1:0]      result_reg;
    logic [4:0]        flags_reg;
    logic [7:0]        ops_done_reg;
    logic              cache_valid_reg;
    logic [2:0]        load_vec;     // index 0 = A, 1 = B, 2 = opcode
    logic [2:0]        need_load;
    logic [2:0][N-1:0] cand_vals;
    logic              accept;

    assign accept = (state_reg == IDLE) && bus.req_valid;

    // While idle the skip decision looks at the incoming request, afterwards at the latched copy.
    always_comb begin
        if (state_reg == IDLE) begin
            cand_vals[0] = bus.req_a;
            cand_vals[1] = bus.req_b;
            cand_vals[2] = {{(N-2){1'b0}}, bus.req_op};
        end else begin
            cand_vals[0] = a_reg;
            cand_vals[1] = b_reg;
            cand_vals[2] = {{(N-2){1'b0}}, op_reg};
        end
    end

    genvar gi;
    generate
        if (CACHE_EN) begin : g_cache
            // Each slot mirrors what the ALU register currently holds, so a match means the load is redundant.
            for (gi = 0; gi < 3; gi++) begin : g_slot
                logic [N-1:0] cache_reg;
                always_ff @(posedge clk) begin
                    if (reset) begin
                        cache_reg <= '0;
                    end else if (load_vec[gi]) begin
                        cache_reg <= alu_data;
                    end
                end
                assign need_load[gi] = !(cache_valid_reg && (cand_vals[gi] == cache_reg));
            end
            always_ff @(posedge clk) begin
                if (reset) begin
                    cache_valid_reg <= 1'b0;
                end else if (load_vec[2]) begin
                    cache_valid_reg <= 1'b1;
                end
            end
        end else begin : g_no_cache
            assign need_load       = 3'b111;
            assign cache_valid_reg = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        load_vec      = 3'b000;
        alu_data      = '0;
        alu_updateRes = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    if (need_load[0])      state_next = LD_A;
                    else if (need_load[1]) state_next = LD_B;
                    else if (need_load[2]) state_next = LD_OP;
                    else                   state_next = EXEC;
                end
            end
            LD_A: begin
                load_vec[0] = 1'b1;
                alu_data    = a_reg;
                if (need_load[1])      state_next = LD_B;
                else if (need_load[2]) state_next = LD_OP;
                else                   state_next = EXEC;
            end
            LD_B: begin
                load_vec[1] = 1'b1;
                alu_data    = b_reg;
                state_next  = need_load[2] ? LD_OP : EXEC;
            end
            LD_OP: begin
                load_vec[2] = 1'b1;
                alu_data    = {{(N-2){1'b0}}, op_reg};
                state_next  = EXEC;
            end
            EXEC: begin
                alu_updateRes = 1'b1;
                state_next    = CAPT;
            end
            CAPT: state_next = RESP;
            RESP: begin
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            result_reg   <= '0;
            flags_reg    <= '0;
            ops_done_reg <= '0;
        end else begin
            if (accept) begin
                a_reg  <= bus.req_a;
                b_reg  <= bus.req_b;
                op_reg <= bus.req_op;
            end
            if (state_reg == CAPT) begin
                result_reg <= alu_result;
                flags_reg  <= alu_flags;
            end
            if ((state_reg == RESP) && bus.rsp_ready) begin
                ops_done_reg <= ops_done_reg + 8'd1;
            end
        end
    end

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.rsp_valid  = (state_reg == RESP);
    assign bus.rsp_result = result_reg;
    assign bus.rsp_flags  = flags_reg;
    assign alu_load_A     = load_vec[0];
    assign alu_load_B     = load_vec[1];
    assign alu_load_Op    = load_vec[2];
    assign ops_done       = ops_done_reg;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: a behavioural registered ALU sits on the strobe bus, and a scoreboard
// queue holds the result/flags each accepted request should produce.
module tb_alu_seq_ctrl;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] alu_data;
    logic         alu_load_A, alu_load_B, alu_load_Op, alu_updateRes;
    logic [N-1:0] alu_result;
    logic [4:0]   alu_flags;
    logic [7:0]   ops_done;

    logic [15:0]  alu_ra, alu_rb;
    logic [1:0]   alu_rop;
    logic [20:0]  exp_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    alu_seq_ctrl_if #(.N(N)) bus();

    alu_seq_ctrl #(.N(N), .CACHE_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .alu_data(alu_data), .alu_load_A(alu_load_A), .alu_load_B(alu_load_B),
        .alu_load_Op(alu_load_Op), .alu_updateRes(alu_updateRes),
        .alu_result(alu_result), .alu_flags(alu_flags), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Returns {result[15:0], V, C, Z, Neg, P}; P is set for an even count of ones, C is borrow on SUB.
    function automatic logic [20:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        logic [16:0] s;
        logic [15:0] r;
        logic        v, c;
        s = '0; r = '0; v = 1'b0; c = 1'b0;
        case (op)
            2'd0: r = ~(a | b);
            2'd1: r = ~(a & b);
            2'd2: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            default: begin
                r = a - b;
                c = (a < b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
        endcase
        return {r, v, c, (r == 16'h0000), r[15], ~^r};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_ra <= '0; alu_rb <= '0; alu_rop <= '0; alu_result <= '0; alu_flags <= '0;
        end else begin
            if (alu_load_A)    alu_ra  <= alu_data;
            if (alu_load_B)    alu_rb  <= alu_data;
            if (alu_load_Op)   alu_rop <= alu_data[1:0];
            if (alu_updateRes) {alu_result, alu_flags} <= alu_model(alu_ra, alu_rb, alu_rop);
        end
    end

    // Called just after a falling edge. Returns at the falling edge where rsp_valid is first seen.
    // mask is {A, B, Op} load strobes observed; viol counts bus-rule breaches.
    task automatic do_req(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                          output int lat, output logic [2:0] mask, output int upd, output int viol,
                          output int waitc, output logic [15:0] res, output logic [4:0] flg);
        int nstb;
        lat = -1; mask = 3'b000; upd = 0; viol = 0; waitc = 0; res = '0; flg = '0;
        bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b; bus.req_op = op;
        while (!bus.req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        exp_q.push_back(alu_model(a, b, op));
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req_valid = 1'b0;
                bus.req_a = 16'($urandom); bus.req_b = 16'($urandom); bus.req_op = 2'($urandom);
            end
            nstb = int'(alu_load_A) + int'(alu_load_B) + int'(alu_load_Op) + int'(alu_updateRes);
            if (nstb > 1) viol++;
            if (alu_load_A)  begin mask[2] = 1'b1; if (alu_data !== a) viol++; end
            if (alu_load_B)  begin mask[1] = 1'b1; if (alu_data !== b) viol++; end
            if (alu_load_Op) begin mask[0] = 1'b1; if (alu_data !== {14'b0, op}) viol++; end
            if (!(alu_load_A || alu_load_B || alu_load_Op) && alu_data !== 16'h0000) viol++;
            if (alu_updateRes) upd++;
            if (bus.rsp_valid) begin
                lat = k; res = bus.rsp_result; flg = bus.rsp_flags;
                break;
            end
        end
        $display("txn a=%h b=%h op=%0d wait=%0d latency=%0d loads=%b result=%h flags=%b",
                 a, b, op, waitc, lat, mask, res, flg);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        n_checks++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_flags, ops_done} !== '0) begin n_fail++;
            $display("FAIL reset_outputs: got valid=%b result=%h flags=%b ops=%0d expected all 0", bus.rsp_valid, bus.rsp_result, bus.rsp_flags, ops_done); end
        n_checks++; if ({alu_load_A, alu_load_B, alu_load_Op, alu_updateRes, alu_data} !== '0) begin n_fail++;
            $display("FAIL reset_alu_bus: got strobes=%b%b%b%b data=%h expected 0", alu_load_A, alu_load_B, alu_load_Op, alu_updateRes, alu_data); end
    endtask

    task automatic test_basic_add();
        int lat, upd, viol, waitc; logic [2:0] mask; logic [15:0] res; logic [4:0] flg; logic [20:0] exp;
        do_req(16'h0003, 16'h0004, 2'd2, lat, mask, upd, viol, waitc, res, flg);
        exp = exp_q.pop_front();
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL add_latency: got %0d expected 6", lat); end
        n_checks++; if (mask !== 3'b111 || upd !== 1) begin n_fail++; $display("FAIL add_strobes: got loads=%b upd=%0d expected 111/1", mask, upd); end
        n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL add_bus_rules: got %0d breaches expected 0", viol); end
        n_checks++; if (res !== 16'h0007 || flg !== 5'b00000) begin n_fail++; $display("FAIL add_result: got %h/%b expected 0007/00000", res, flg); end
        n_checks++; if ({res, flg} !== exp) begin n_fail++; $display("FAIL add_scoreboard: got %h expected %h", {res, flg}, exp); end
        @(negedge clk);
        n_checks++; if (ops_done !== 8'd1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_ops_done: got ops=%0d valid=%b expected 1/0", ops_done, bus.rsp_valid); end
    endtask

    task automatic test_sub_overflow();
        int lat, upd, viol, waitc; logic [2:0] mask; logic [15:0] res; logic [4:0] flg; logic [20:0] exp;
        do_req(16'h8000, 16'h0001, 2'd3, lat, mask, upd, viol, waitc, res, flg);
        exp = exp_q.pop_front();
        n_checks++; if (lat !== 6 || mask !== 3'b111 || viol !== 0) begin n_fail++; $display("FAIL sub_sequence: got lat=%0d loads=%b breaches=%0d expected 6/111/0", lat, mask, viol); end
        n_checks++; if (res !== 16'h7FFF || flg !== 5'b10000) begin n_fail++; $display("FAIL sub_result: got %h/%b expected 7fff/10000", res, flg); end
        n_checks++; if ({res, flg} !== exp) begin n_fail++; $display("FAIL sub_scoreboard: got %h expected %h", {res, flg}, exp); end
    endtask

    task automatic test_cache_skip();
        int lat, upd, viol, waitc; logic [2:0] mask; logic [15:0] res; logic [4:0] flg; logic [20:0] exp;
        do_req(16'h8000, 16'h0001, 2'd3, lat, mask, upd, viol, waitc, res, flg);
        exp = exp_q.pop_front();
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL skip_all_latency: got %0d expected 3", lat); end
        n_checks++; if (mask !== 3'b000 || upd !== 1 || viol !== 0) begin n_fail++; $display("FAIL skip_all_strobes: got loads=%b upd=%0d breaches=%0d expected 000/1/0", mask, upd, viol); end
        n_checks++; if (res !== 16'h7FFF || {res, flg} !== exp) begin n_fail++; $display("FAIL skip_all_result: got %h expected %h", {res, flg}, exp); end
        do_req(16'h8000, 16'h0002, 2'd3, lat, mask, upd, viol, waitc, res, flg);
        exp = exp_q.pop_front();
        n_checks++; if (lat !== 4 || mask !== 3'b010) begin n_fail++; $display("FAIL skip_b_only: got lat=%0d loads=%b expected 4/010", lat, mask); end
        n_checks++; if (res !== 16'h7FFE || flg !== 5'b10001 || {res, flg} !== exp) begin n_fail++; $display("FAIL skip_b_result: got %h/%b expected 7ffe/10001", res, flg); end
    endtask

    task automatic test_back_to_back();
        int lat, upd, viol, waitc; logic [2:0] mask; logic [15:0] res; logic [4:0] flg; logic [20:0] exp;
        do_req(16'h00FF, 16'h0F0F, 2'd1, lat, mask, upd, viol, waitc, res, flg);
        exp = exp_q.pop_front();
        n_checks++; if (lat !== 6 || {res, flg} !== exp) begin n_fail++; $display("FAIL b2b_nand: got lat=%0d out=%h expected 6/%h", lat, {res, flg}, exp); end
        do_req(16'h00FF, 16'h0F0F, 2'd0, lat, mask, upd, viol, waitc, res, flg);
        exp = exp_q.pop_front();
        n_checks++; if (waitc !== 1) begin n_fail++; $display("FAIL b2b_accept_gap: got %0d cycles expected 1", waitc); end
        n_checks++; if (lat !== 4 || mask !== 3'b001 || viol !== 0) begin n_fail++; $display("FAIL b2b_op_only: got lat=%0d loads=%b breaches=%0d expected 4/001/0", lat, mask, viol); end
        n_checks++; if ({res, flg} !== exp) begin n_fail++; $display("FAIL b2b_nor_result: got %h expected %h", {res, flg}, exp); end
    endtask

    task automatic test_backpressure();
        int lat, upd, viol, waitc, bad; logic [2:0] mask; logic [15:0] res, held; logic [4:0] flg; logic [20:0] exp; logic [7:0] od0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        do_req(16'h0001, 16'h0001, 2'd2, lat, mask, upd, viol, waitc, res, flg);
        exp = exp_q.pop_front();
        n_checks++; if (lat !== 6 || {res, flg} !== exp) begin n_fail++; $display("FAIL bp_first: got lat=%0d out=%h expected 6/%h", lat, {res, flg}, exp); end
        held = bus.rsp_result; od0 = ops_done; bad = 0;
        bus.req_valid = 1'b1; bus.req_a = 16'h0005; bus.req_b = 16'h0006; bus.req_op = 2'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== held || bus.req_ready !== 1'b0) bad++;
            if ({alu_load_A, alu_load_B, alu_load_Op, alu_updateRes} !== 4'b0000) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || ops_done !== 8'(od0 + 8'd1)) begin n_fail++;
            $display("FAIL bp_release: got ready=%b valid=%b ops=%0d expected 1/0/%0d", bus.req_ready, bus.rsp_valid, ops_done, 8'(od0 + 8'd1)); end
        do_req(16'h0005, 16'h0006, 2'd2, lat, mask, upd, viol, waitc, res, flg);
        exp = exp_q.pop_front();
        n_checks++; if (waitc !== 0 || lat !== 5 || mask !== 3'b110) begin n_fail++; $display("FAIL bp_next_req: got wait=%0d lat=%0d loads=%b expected 0/5/110", waitc, lat, mask); end
        n_checks++; if ({res, flg} !== exp) begin n_fail++; $display("FAIL bp_next_result: got %h expected %h", {res, flg}, exp); end
    endtask

    task automatic test_reset_mid();
        int lat, upd, viol, waitc; logic [2:0] mask; logic [15:0] res; logic [4:0] flg; logic [20:0] exp;
        bus.req_valid = 1'b1; bus.req_a = 16'h0009; bus.req_b = 16'h0007; bus.req_op = 2'd3;
        waitc = 0;
        while (!bus.req_ready && waitc < 50) begin @(negedge clk); waitc++; end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_checks++; if (alu_load_A !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ld_a: got %b expected 1", alu_load_A); end
        @(negedge clk);
        n_checks++; if (alu_load_B !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ld_b: got %b expected 1", alu_load_B); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_flags, ops_done, alu_load_A, alu_load_B, alu_load_Op, alu_updateRes, alu_data} !== '0) begin n_fail++;
            $display("FAIL rst_mid_outputs: got valid=%b result=%h flags=%b ops=%0d data=%h expected all 0", bus.rsp_valid, bus.rsp_result, bus.rsp_flags, ops_done, alu_data); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle: got req_ready=%b expected 1", bus.req_ready); end
        reset = 1'b0;
        do_req(16'h0009, 16'h0007, 2'd3, lat, mask, upd, viol, waitc, res, flg);
        exp = exp_q.pop_front();
        n_checks++; if (lat !== 6 || mask !== 3'b111) begin n_fail++; $display("FAIL rst_mid_reload: got lat=%0d loads=%b expected 6/111", lat, mask); end
        n_checks++; if (res !== 16'h0002 || {res, flg} !== exp) begin n_fail++; $display("FAIL rst_mid_result: got %h expected %h", {res, flg}, exp); end
        @(negedge clk);
        n_checks++; if (ops_done !== 8'd1) begin n_fail++; $display("FAIL rst_mid_ops_done: got %0d expected 1", ops_done); end
    endtask

    task automatic test_counter_wrap();
        int lat, upd, viol, waitc, bad; logic [2:0] mask; logic [15:0] res; logic [4:0] flg; logic [20:0] exp;
        bad = 0;
        for (int i = 0; i < 254; i++) begin
            do_req(16'h0009, 16'h0007, 2'd3, lat, mask, upd, viol, waitc, res, flg);
            exp = exp_q.pop_front();
            if (lat !== 3 || mask !== 3'b000 || viol !== 0 || {res, flg} !== exp) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL wrap_cached_runs: got %0d bad transactions expected 0", bad); end
        @(negedge clk);
        n_checks++; if (ops_done !== 8'd255) begin n_fail++; $display("FAIL wrap_at_255: got %0d expected 255", ops_done); end
        do_req(16'h0009, 16'h0007, 2'd3, lat, mask, upd, viol, waitc, res, flg);
        exp = exp_q.pop_front();
        @(negedge clk);
        n_checks++; if (ops_done !== 8'd0) begin n_fail++; $display("FAIL wrap_to_0: got %0d expected 0", ops_done); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0; bus.rsp_ready = 1'b1;
        test_reset();
        test_basic_add();
        test_sub_overflow();
        test_cache_skip();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
